// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: IDLE -> REQ -> RESP, req/ack bus with byte masks, extended load write-back.
// Optional misaligned-access trap: define YSYX_LSU_MISALIGN_TRAP_EN.
module ysyx_24100005_lsu #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_is_load,
  input  logic                   in_is_store,
  input  logic [2:0]             in_funct3,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0]  in_wdata,
  input  logic [RADDR_WIDTH-1:0] in_rd,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  output logic [3:0]             mem_wmask,
  input  logic                   mem_ack,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   wb_wen,
  output logic [RADDR_WIDTH-1:0] wb_waddr,
  output logic [DATA_WIDTH-1:0]  wb_wdata,
  output logic                   done,
  output logic                   err
);

  localparam int CNT_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;
  logic                   r_is_load;
  logic                   r_is_store;
  logic [2:0]             r_funct3;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [RADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]  r_rdata;

  logic                   w_accept;
  logic                   w_f3_known;
  logic                   w_misalign;
  logic                   w_illegal;
  logic [7:0]             w_ld_byte;
  logic [15:0]            w_ld_half;
  logic [DATA_WIDTH-1:0]  w_ld_ext;
  logic [DATA_WIDTH-1:0]  w_st_data;
  logic [3:0]             w_st_mask;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_f3_known = 1'b0;
    case (in_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_known = 1'b1;
      default:                                 w_f3_known = 1'b0;
    endcase
  end

`ifdef YSYX_LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((in_funct3[1:0] == 2'b01) & in_addr[0]) |
                      ((in_funct3[1:0] == 2'b10) & (in_addr[1:0] != 2'b00));
`else
  // Low address bits past lane selection are simply ignored in this build.
  assign w_misalign = 1'b0;
`endif

  // Illegal ops skip the bus entirely and report through RESP with err set.
  assign w_illegal = (in_is_load == in_is_store) | ~w_f3_known |
                     (in_is_store & in_funct3[2]) | w_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_load  <= in_is_load;
            r_is_store <= in_is_store;
            r_funct3   <= in_funct3;
            r_addr     <= in_addr;
            r_wdata    <= in_wdata;
            r_rd       <= in_rd;
            r_cnt      <= '0;
            r_err      <= w_illegal;
            r_state    <= w_illegal ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          // An ack arriving in the final allowed cycle still completes normally.
          if (mem_ack) begin
            r_rdata <= mem_rdata;
            r_state <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ld_byte = r_rdata[7:0];
    case (r_addr[1:0])
      2'b00:   w_ld_byte = r_rdata[7:0];
      2'b01:   w_ld_byte = r_rdata[15:8];
      2'b10:   w_ld_byte = r_rdata[23:16];
      default: w_ld_byte = r_rdata[31:24];
    endcase
    w_ld_half = r_addr[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_ext = {24'd0, w_ld_byte};
      3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_ext = {16'd0, w_ld_half};
      default: w_ld_ext = r_rdata;
    endcase
  end

  // Store data is replicated across lanes so the mask alone picks the target bytes.
  always_comb begin
    case (r_funct3[1:0])
      2'b00: begin
        w_st_data = {4{r_wdata[7:0]}};
        w_st_mask = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        w_st_data = {2{r_wdata[15:0]}};
        w_st_mask = r_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_st_data = r_wdata;
        w_st_mask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = 4'b0000;
    if (r_state == S_REQ) begin
      mem_req  = 1'b1;
      mem_we   = r_is_store;
      mem_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
      if (r_is_store) begin
        mem_wdata = w_st_data;
        mem_wmask = w_st_mask;
      end
    end
  end

  always_comb begin
    done     = 1'b0;
    err      = 1'b0;
    wb_wen   = 1'b0;
    wb_waddr = '0;
    wb_wdata = '0;
    if (r_state == S_RESP) begin
      done = 1'b1;
      err  = r_err;
      if (!r_err && r_is_load && (r_rd != '0)) begin
        wb_wen   = 1'b1;
        wb_waddr = r_rd;
        wb_wdata = w_ld_ext;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed table-driven bench for ysyx_24100005_lsu (built with a 4-cycle bus timeout).
module tb_ysyx_24100005_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_24100005_lsu #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .done(done), .err(err)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          ack_at;   // cycle index after accept at which ack is driven, -1 = never
    logic [31:0] rdata;
    logic        e_err;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_mask;
    logic [31:0] e_mwdata;
    int          e_req;    // number of cycles mem_req is high
    int          e_lat;    // cycle index after accept where done pulses
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input int ack_at, input logic [31:0] rdata,
                              input logic e_err, input logic e_wen, input logic [31:0] e_wdata,
                              input logic [3:0] e_mask, input logic [31:0] e_mwdata,
                              input int e_req, input int e_lat);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.ack_at = ack_at; v.rdata = rdata; v.e_err = e_err; v.e_wen = e_wen;
    v.e_wdata = e_wdata; v.e_mask = e_mask; v.e_mwdata = e_mwdata;
    v.e_req = e_req; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nreq;
    int lat;
    bit seen;
    nreq = 0;
    lat  = -1;
    seen = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), in_ready, 1);
    in_valid = 1'b1; in_is_load = v.ld; in_is_store = v.st; in_funct3 = v.f3;
    in_addr = v.addr; in_wdata = v.wdata; in_rd = v.rd;
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      mem_ack   = (c == v.ack_at);
      mem_rdata = (c == v.ack_at) ? v.rdata : 32'hA5A5_A5A5;
      #1;
      if (mem_req) begin
        nreq++;
        chk($sformatf("v%0d_maddr", idx), mem_addr, v.addr & ~32'h3);
        chk($sformatf("v%0d_mwe", idx), mem_we, v.st);
        chk($sformatf("v%0d_mmask", idx), mem_wmask, v.e_mask);
        if (v.st) chk($sformatf("v%0d_mwdata", idx), mem_wdata, v.e_mwdata);
      end
      if (done) begin
        seen = 1'b1;
        lat  = c;
        chk($sformatf("v%0d_err", idx), err, v.e_err);
        chk($sformatf("v%0d_wen", idx), wb_wen, v.e_wen);
        if (v.e_wen) begin
          chk($sformatf("v%0d_waddr", idx), wb_waddr, v.rd);
          chk($sformatf("v%0d_wdata", idx), wb_wdata, v.e_wdata);
        end
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, v.e_lat);
    chk($sformatf("v%0d_reqcycles", idx), nreq, v.e_req);
    chk($sformatf("v%0d_post_ready", idx), in_ready, 1);
    chk($sformatf("v%0d_post_done", idx), {done, err, wb_wen}, 0);
    $display("vec %0d: ld=%0b st=%0b f3=%03b addr=%08h lat=%0d req=%0d wb=%08h",
             idx, v.ld, v.st, v.f3, v.addr, lat, nreq, v.e_wdata);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = 3'b000; in_addr = '0; in_wdata = '0; in_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    vecs.push_back(mk(1,0,3'b010,32'h8000_0004,0,5, 2,32'hDEAD_BEEF,0,1,32'hDEAD_BEEF,4'h0,0,3,3));
    vecs.push_back(mk(1,0,3'b000,32'h8000_0003,0,7, 0,32'h80FF_0011,0,1,32'hFFFF_FF80,4'h0,0,1,1));
    vecs.push_back(mk(1,0,3'b100,32'h8000_0003,0,8, 0,32'h80FF_0011,0,1,32'h0000_0080,4'h0,0,1,1));
    vecs.push_back(mk(1,0,3'b001,32'h8000_0002,0,9, 1,32'h80FF_0011,0,1,32'hFFFF_80FF,4'h0,0,2,2));
    vecs.push_back(mk(1,0,3'b101,32'h8000_0002,0,10,1,32'h80FF_0011,0,1,32'h0000_80FF,4'h0,0,2,2));
    vecs.push_back(mk(1,0,3'b000,32'h8000_0002,0,11,0,32'h80FF_0011,0,1,32'hFFFF_FFFF,4'h0,0,1,1));
    vecs.push_back(mk(1,0,3'b001,32'h8000_0000,0,12,0,32'h80FF_0011,0,1,32'h0000_0011,4'h0,0,1,1));
    vecs.push_back(mk(1,0,3'b010,32'h8000_0000,0,0, 0,32'h1234_5678,0,0,32'h0,        4'h0,0,1,1));
    vecs.push_back(mk(0,1,3'b000,32'h8000_0001,32'h1234_5678,3,0,0,0,0,0,4'b0010,32'h7878_7878,1,1));
    vecs.push_back(mk(0,1,3'b001,32'h8000_0002,32'h1234_5678,3,0,0,0,0,0,4'b1100,32'h5678_5678,1,1));
    vecs.push_back(mk(0,1,3'b010,32'h8000_0000,32'hCAFE_F00D,3,1,0,0,0,0,4'b1111,32'hCAFE_F00D,2,2));
    // ack in the last allowed REQ cycle, then a true timeout
    vecs.push_back(mk(1,0,3'b010,32'h8000_0008,0,4, 3,32'h0BAD_F00D,0,1,32'h0BAD_F00D,4'h0,0,4,4));
    vecs.push_back(mk(1,0,3'b010,32'h8000_0008,0,4,-1,32'h0,        1,0,32'h0,        4'h0,0,4,4));
    vecs.push_back(mk(1,1,3'b010,32'h8000_0000,0,6,-1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,3'b011,32'h8000_0000,0,6,-1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,3'b010,32'h8000_0000,0,6,-1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,3'b100,32'h8000_0000,0,6,-1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,3'b110,32'h8000_0000,0,6,-1,0,1,0,0,0,0,0,0));
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0,1,3'b010,32'h8000_0002,32'h1122_3344,3,-1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,3'b001,32'h8000_0001,0,13,-1,0,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,3'b010,32'h8000_0003,0,14,-1,0,1,0,0,0,0,0,0));
`else
    vecs.push_back(mk(0,1,3'b010,32'h8000_0002,32'h1122_3344,3,0,0,0,0,0,4'b1111,32'h1122_3344,1,1));
    vecs.push_back(mk(1,0,3'b001,32'h8000_0001,0,13,0,32'h80FF_0011,0,1,32'h0000_0011,4'h0,0,1,1));
    vecs.push_back(mk(1,0,3'b010,32'h8000_0003,0,14,0,32'hFEED_FACE,0,1,32'hFEED_FACE,4'h0,0,1,1));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_outs", {mem_req, mem_we, mem_wmask, done, err, wb_wen}, 0);
    rst = 1'b0;

    // stray acks while idle must be ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("stray_ack_idle", {mem_req, done, err, wb_wen}, 0);
    end
    mem_ack = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // reset while a request is outstanding drops the op
    @(negedge clk);
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h8000_0010; in_rd = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_load = 1'b0;
    chk("rreq_req_high", mem_req, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rreq_req_low", mem_req, 0);
    chk("rreq_ready", in_ready, 1);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rreq_no_done", {done, err, wb_wen, mem_req}, 0);
    end
    mem_ack = 1'b0;
    $display("seq reset_in_req: op dropped");
    run_vec(vecs[0], 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
